aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Sequences the iterative AES round datapath: initial AddRoundKey load, NR feedback rounds, then result hand-off with a valid/ready handshake.
- Drives the datapath input-mux select, state-register enable, key-schedule load/advance, round index and final-round MixColumns bypass.
- Sits between the block-level start/result interface and the round datapath plus key-expansion unit.

Parameters:
- NR, 10, number of cipher rounds (10/12/14 for AES-128/192/256); legal range 1..15.
- CNT_W, 4, round-counter width; fixed at 4, which covers NR up to 15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to begin one block; accepted only when ready=1.
- clear  in  1  synchronous abort; returns the FSM to IDLE.
- ready  out  1  idle, can accept start.
- busy  out  1  LOAD or ROUND in progress.
- sel  out  1  datapath mux select: 0 = external plaintext, 1 = round feedback.
- state_en  out  1  state-register write enable.
- key_load  out  1  load cipher key into key schedule; round-0 key presented.
- key_en  out  1  advance key schedule one round key.
- round  out  CNT_W  current round index, 0..NR.
- last_round  out  1  final round; datapath bypasses MixColumns.
- out_valid  out  1  result held in state register.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-low.
- Reset: FSM = IDLE, round = 0. Outputs: ready = 1; busy, sel, state_en, key_load, key_en, last_round and out_valid = 0.
- Output timing: all outputs decode from registered state and round (Moore); no combinational path from inputs to outputs.
- IDLE:
  - ready = 1, round = 0.
  - start = 1 -> LOAD.
  - out_ready is ignored.
- LOAD (exactly 1 cycle):
  - sel = 0, state_en = 1, key_load = 1, round = 0, busy = 1.
  - Performs the initial AddRoundKey.
  - Next: ROUND with round = 1.
- ROUND:
  - sel = 1, state_en = 1, key_en = 1, busy = 1.
  - last_round = (round == NR).
  - Counter increments by 1 each cycle.
  - On the round == NR cycle -> DONE; the counter holds at NR and never wraps.
- DONE:
  - out_valid = 1, state_en = 0, round = NR.
  - Result is held stable until out_ready = 1, then -> IDLE (round cleared to 0).
  - out_ready may be held high continuously; DONE then lasts exactly 1 cycle.
- Latency: start accepted in cycle T -> LOAD in T+1 -> rounds 1..NR in T+2..T+NR+1 -> out_valid first high in T+NR+2 (T+12 for NR = 10).
- Throughput: one block per NR+3 cycles minimum; start is not pipelined with DONE.
- start outside IDLE is ignored and not queued.
- clear:
  - Highest priority, any state -> IDLE next cycle, round = 0, no out_valid.
  - clear and start together in IDLE -> stays IDLE.
- Reset mid-operation: immediate return to reset values; any partial result is discarded.

Decomposition:
- Shared package aes_pkg holds:
  - state enum (IDLE, LOAD, ROUND, DONE);
  - constants AES128_NR = 10, AES192_NR = 12, AES256_NR = 14;
  - ROUND_CNT_W = 4.
- Single module; no sub-module needed (counter and FSM are inline).

Test Plan:
- Reset with start held high -> ready = 1, all other outputs 0; after release, start in IDLE gives LOAD the next cycle.
- start pulse, out_ready = 1, NR = 10 -> LOAD in cycle 1 (sel = 0, key_load = 1); rounds 1..10 in cycles 2..11 (sel = 1, key_en = 1); last_round only in cycle 11; out_valid in cycle 12 for exactly 1 cycle; ready in cycle 13.
- out_ready held low 5 cycles in DONE -> out_valid stays high 6 cycles, round = 10, state_en = 0; IDLE the cycle after out_ready rises.
- start pulses during ROUND and DONE -> ignored; exactly one out_valid per accepted start.
- clear asserted at round = 5 -> IDLE next cycle, round = 0, out_valid never asserted; a new start then completes normally in 12 cycles.
- NR = 14 build -> last_round when round = 14; out_valid at T+16. Also rst_n dropped mid-ROUND -> outputs reset asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM state type and AES round-count constants for the round sequencer.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_e;
    localparam int AES128_NR   = 10;
    localparam int AES192_NR   = 12;
    localparam int AES256_NR   = 14;
    localparam int ROUND_CNT_W = 4;
endpackage

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: Moore FSM driving the iterative AES round datapath and key schedule.
// Outputs are registered from the next state, so nothing passes combinationally from inputs to outputs.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR    = AES128_NR,
    parameter int CNT_W = ROUND_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    output logic             ready,
    output logic             busy,
    output logic             sel,
    output logic             state_en,
    output logic             key_load,
    output logic             key_en,
    output logic [CNT_W-1:0] round,
    output logic             last_round,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam logic [CNT_W-1:0] NR_C = CNT_W'(NR);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic             ready_q, ready_d, busy_q, busy_d, sel_q, sel_d;
    logic             state_en_q, state_en_d, key_load_q, key_load_d, key_en_q, key_en_d;
    logic             last_round_q, last_round_d, out_valid_q, out_valid_d;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        if (clear) begin
            state_d = IDLE;
            round_d = '0;
        end else begin
            case (state_q)
                IDLE:  state_d = start ? LOAD : IDLE;
                LOAD: begin
                    state_d = ROUND;
                    round_d = CNT_W'(1);
                end
                ROUND: begin
                    state_d = (round_q == NR_C) ? DONE : ROUND;
                    round_d = (round_q == NR_C) ? round_q : round_q + 1'b1;
                end
                DONE: begin
                    state_d = out_ready ? IDLE : DONE;
                    round_d = out_ready ? '0 : round_q;
                end
            endcase
        end
        ready_d      = state_d == IDLE;
        busy_d       = state_d == LOAD || state_d == ROUND;
        sel_d        = state_d == ROUND;
        state_en_d   = state_d == LOAD || state_d == ROUND;
        key_load_d   = state_d == LOAD;
        key_en_d     = state_d == ROUND;
        last_round_d = state_d == ROUND && round_d == NR_C;
        out_valid_d  = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            round_q      <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            sel_q        <= 1'b0;
            state_en_q   <= 1'b0;
            key_load_q   <= 1'b0;
            key_en_q     <= 1'b0;
            last_round_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            sel_q        <= sel_d;
            state_en_q   <= state_en_d;
            key_load_q   <= key_load_d;
            key_en_q     <= key_en_d;
            last_round_q <= last_round_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign sel        = sel_q;
    assign state_en   = state_en_q;
    assign key_load   = key_load_q;
    assign key_en     = key_en_q;
    assign round      = round_q;
    assign last_round = last_round_q;
    assign out_valid  = out_valid_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed checks of the AES round sequencer for NR=10 and NR=14 builds.
module tb_aes_round_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, start, start14, clear, out_ready;
    logic       ready, busy, sel, state_en, key_load, key_en, last_round, out_valid;
    logic       ready14, busy14, sel14, state_en14, key_load14, key_en14, last_round14, out_valid14;
    logic [3:0] round, round14;
    logic [11:0] v10, v14;
    int         n_chk = 0, n_pass = 0, nv, lat;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .ready(ready), .busy(busy), .sel(sel), .state_en(state_en),
        .key_load(key_load), .key_en(key_en), .round(round),
        .last_round(last_round), .out_valid(out_valid), .out_ready(out_ready)
    );

    aes_round_sequencer #(.NR(14), .CNT_W(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start14), .clear(clear),
        .ready(ready14), .busy(busy14), .sel(sel14), .state_en(state_en14),
        .key_load(key_load14), .key_en(key_en14), .round(round14),
        .last_round(last_round14), .out_valid(out_valid14), .out_ready(out_ready)
    );

    // bit order: ready busy sel state_en key_load key_en last_round out_valid round[3:0]
    assign v10 = {ready, busy, sel, state_en, key_load, key_en, last_round, out_valid, round};
    assign v14 = {ready14, busy14, sel14, state_en14, key_load14, key_en14, last_round14, out_valid14, round14};

    localparam logic [11:0] IDLE_V = 12'b1000_0000_0000;
    localparam logic [11:0] LOAD_V = 12'b0101_1000_0000;

    function automatic logic [11:0] rnd_v(int r, int nr);
        return {8'b0111_0100 | {6'b0, 1'(r == nr), 1'b0}, 4'(r)};
    endfunction

    function automatic logic [11:0] done_v(int nr);
        return {8'b0000_0001, 4'(nr)};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; start14 = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_v10", v10, IDLE_V);
        check("rst_v14", v14, IDLE_V);
        rst_n = 1'b1;
        step();
        check("load", v10, LOAD_V);
        start = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            step();
            check($sformatf("round%0d", r), v10, rnd_v(r, 10));
        end
        step();
        check("done_1cyc", v10, done_v(10));
        step();
        check("ready_after", v10, IDLE_V);

        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("load_hold", v10, LOAD_V);
        repeat (10) step();
        check("r10_hold", v10, rnd_v(10, 10));
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("done_hold%0d", i), v10, done_v(10));
            if (i == 5) out_ready = 1'b1;
        end
        step();
        check("idle_hold", v10, IDLE_V);

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("ign_r3", v10, rnd_v(3, 10));
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_r4", v10, rnd_v(4, 10));
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            start = out_valid;
            if (out_valid) nv++;
        end
        start = 1'b0;
        check("one_ov", nv, 1);
        check("idle_ign", v10, IDLE_V);

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("clr_r5", v10, rnd_v(5, 10));
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_idle", v10, IDLE_V);
        nv = 0;
        repeat (3) begin
            step();
            if (out_valid) nv++;
        end
        check("clr_no_ov", nv, 0);
        clear = 1'b1;
        start = 1'b1;
        step();
        check("clr_start", v10, IDLE_V);
        clear = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
            start = 1'b0;
        end while (!out_valid && lat < 30);
        check("lat10", lat, 12);
        step();
        check("idle_lat10", v10, IDLE_V);

        start14 = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
            start14 = 1'b0;
            if (lat == 14) check("nr14_r13", v14, rnd_v(13, 14));
            if (lat == 15) check("nr14_r14", v14, rnd_v(14, 14));
        end while (!out_valid14 && lat < 30);
        check("lat14", lat, 16);
        check("done14", v14, done_v(14));

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("pre_async", v10, rnd_v(4, 10));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", v10, IDLE_V);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst", v10, IDLE_V);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
